cell_search_ctrl: RTL and testbench

Sequences the PSS detector through cell search and tracking. It watches the PSS detector's N_id_2 detections and a sample strobe, then drives the detector mode and requested N_id_2. It declares lock after a confirmed periodic re-detection, counts missed PSS windows, and falls back to full search after too many misses. It also gates CFO updates so that only CFO estimates belonging to accepted detections reach the DDS phase accumulator.

---
 rtl/cell_search_ctrl.sv | 159 +++++++++++++++
 tb/tb_cell_search_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cell_search_ctrl.sv
// Cell search / tracking sequencer for the PSS detector: acquires an N_id_2,
// tracks it on the PSS_PERIOD grid, and forwards CFO estimates only for accepted detections.
module cell_search_ctrl #(
    parameter int   PSS_PERIOD  = 38400,
    parameter int   WINDOW_HALF = 8,
    parameter int   MAX_MISSES  = 3,
    parameter int   CFO_DW      = 20,
    localparam int  TIMER_DW    = $clog2(PSS_PERIOD + WINDOW_HALF + 1),
    localparam int  MISS_DW     = $clog2(MAX_MISSES + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic                     s_axis_in_tvalid,
    input  logic                     N_id_2_valid_i,
    input  logic [1:0]               N_id_2_i,
    input  logic                     CFO_valid_i,
    input  logic signed [CFO_DW-1:0] CFO_DDS_inc_i,
    output logic [1:0]               mode_o,
    output logic [1:0]               requested_N_id_2_o,
    output logic                     locked_o,
    output logic                     lock_lost_o,
    output logic                     CFO_valid_o,
    output logic signed [CFO_DW-1:0] CFO_DDS_inc_o,
    output logic [MISS_DW-1:0]       miss_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_WAIT, S_TRACK} state_t;

    localparam logic [1:0] MODE_SEARCH = 2'd0;
    localparam logic [1:0] MODE_TRACK  = 2'd1;
    localparam logic [1:0] MODE_PAUSE  = 2'd2;

    localparam logic [TIMER_DW-1:0] T_OPEN   = TIMER_DW'(PSS_PERIOD - WINDOW_HALF);
    localparam logic [TIMER_DW-1:0] T_CLOSE  = TIMER_DW'(PSS_PERIOD + WINDOW_HALF);
    localparam logic [TIMER_DW-1:0] T_PERIOD = TIMER_DW'(PSS_PERIOD);
    localparam logic [MISS_DW-1:0]  MISS_LAST = MISS_DW'(MAX_MISSES - 1);

    state_t                     state_q;
    logic [TIMER_DW-1:0]        timer_q;
    logic [MISS_DW-1:0]         miss_cnt_q;
    logic [1:0]                 mode_q;
    logic [1:0]                 req_id_q;
    logic                       locked_q;
    logic                       lock_lost_q;
    logic                       cfo_armed_q;
    logic                       cfo_valid_q;
    logic signed [CFO_DW-1:0]   cfo_inc_q;

    logic hit;
    logic acquire;
    logic arm_now;
    logic cfo_fwd;

    always_comb begin
        hit     = (state_q == S_TRACK) && N_id_2_valid_i && (N_id_2_i == req_id_q);
        acquire = (state_q == S_SEARCH) && N_id_2_valid_i;
        arm_now = enable_i && (hit || acquire);
        // Arming from a same-cycle detection counts, so its CFO is forwarded.
        cfo_fwd = enable_i && CFO_valid_i && (cfo_armed_q || arm_now);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            miss_cnt_q  <= '0;
            mode_q      <= MODE_PAUSE;
            req_id_q    <= 2'd0;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
            cfo_armed_q <= 1'b0;
            cfo_valid_q <= 1'b0;
            cfo_inc_q   <= '0;
        end else begin
            lock_lost_q <= 1'b0;
            cfo_valid_q <= cfo_fwd;
            if (cfo_fwd) begin
                cfo_inc_q   <= CFO_DDS_inc_i;
                cfo_armed_q <= 1'b0;
            end else if (arm_now) begin
                cfo_armed_q <= 1'b1;
            end

            if (!enable_i) begin
                state_q     <= S_IDLE;
                mode_q      <= MODE_PAUSE;
                locked_q    <= 1'b0;
                timer_q     <= '0;
                miss_cnt_q  <= '0;
                cfo_armed_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        timer_q     <= '0;
                        miss_cnt_q  <= '0;
                        cfo_armed_q <= 1'b0;
                        state_q     <= S_SEARCH;
                        mode_q      <= MODE_SEARCH;
                    end
                    S_SEARCH: begin
                        if (N_id_2_valid_i) begin
                            req_id_q <= N_id_2_i;
                            timer_q  <= '0;
                            state_q  <= S_WAIT;
                            mode_q   <= MODE_PAUSE;
                        end
                    end
                    S_WAIT: begin
                        if (s_axis_in_tvalid)
                            timer_q <= timer_q + TIMER_DW'(1);
                        if (timer_q == T_OPEN) begin
                            state_q <= S_TRACK;
                            mode_q  <= MODE_TRACK;
                        end
                    end
                    S_TRACK: begin
                        if (hit) begin
                            timer_q    <= '0;
                            miss_cnt_q <= '0;
                            locked_q   <= 1'b1;
                            state_q    <= S_WAIT;
                            mode_q     <= MODE_PAUSE;
                        end else if (timer_q == T_CLOSE) begin
                            // Pull back by one period so the next window stays on the nominal grid.
                            timer_q <= timer_q - T_PERIOD;
                            if (miss_cnt_q == MISS_LAST) begin
                                miss_cnt_q  <= '0;
                                locked_q    <= 1'b0;
                                lock_lost_q <= locked_q;
                                state_q     <= S_SEARCH;
                                mode_q      <= MODE_SEARCH;
                            end else begin
                                miss_cnt_q <= miss_cnt_q + MISS_DW'(1);
                                state_q    <= S_WAIT;
                                mode_q     <= MODE_PAUSE;
                            end
                        end else if (s_axis_in_tvalid) begin
                            timer_q <= timer_q + TIMER_DW'(1);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        mode_q  <= MODE_PAUSE;
                    end
                endcase
            end
        end
    end

    assign mode_o             = mode_q;
    assign requested_N_id_2_o = req_id_q;
    assign locked_o           = locked_q;
    assign lock_lost_o        = lock_lost_q;
    assign CFO_valid_o        = cfo_valid_q;
    assign CFO_DDS_inc_o      = cfo_inc_q;
    assign miss_cnt_o         = miss_cnt_q;

endmodule

// File: tb/tb_cell_search_ctrl.sv
// Directed-sequence bench for cell_search_ctrl; expectations come from strobe positions
// counted in the bench relative to the last accepted detection.
module tb_cell_search_ctrl;
    localparam int P  = 100;
    localparam int W  = 4;
    localparam int M  = 2;
    localparam int DW = 20;

    logic          clk = 1'b0;
    logic          rst, en, strb, nv, cv;
    logic [1:0]    nid;
    logic [DW-1:0] cinc;
    logic [1:0]    mode, req, miss;
    logic          locked, lost, cvo;
    logic [DW-1:0] cinc_o;

    int vectors = 0;
    int miscompares = 0;
    int pos = 0;
    int pb, hit_at;
    bit got;
    logic s;
    logic [1:0] r1, r2, r3, r4, wrong;
    logic [DW-1:0] v1, v2, v3, v4, v5;

    always #5 clk = ~clk;

    cell_search_ctrl #(.PSS_PERIOD(P), .WINDOW_HALF(W), .MAX_MISSES(M), .CFO_DW(DW)) dut (
        .clk_i(clk), .reset_i(rst), .enable_i(en), .s_axis_in_tvalid(strb),
        .N_id_2_valid_i(nv), .N_id_2_i(nid), .CFO_valid_i(cv), .CFO_DDS_inc_i(cinc),
        .mode_o(mode), .requested_N_id_2_o(req), .locked_o(locked), .lock_lost_o(lost),
        .CFO_valid_o(cvo), .CFO_DDS_inc_o(cinc_o), .miss_cnt_o(miss)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given pulses; pos tracks strobes since the last anchor.
    task automatic cyc(input logic d_v, input logic [1:0] d_id, input logic c_v,
                       input logic [DW-1:0] c_inc, input logic st);
        nv = d_v; nid = d_id; cv = c_v; cinc = c_inc; strb = st;
        @(posedge clk); #1;
        if (st) pos++;
        nv = 1'b0; cv = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; strb = 1'b0; nv = 1'b0; cv = 1'b0; nid = 2'd0; cinc = '0;
        r1 = 2'($urandom_range(2, 0)); r2 = 2'($urandom_range(2, 0));
        r3 = 2'($urandom_range(2, 0)); r4 = 2'($urandom_range(2, 0));
        wrong = 2'((int'(r1) + 1) % 3);
        v1 = DW'($urandom); v2 = DW'($urandom); v3 = DW'($urandom);
        v4 = DW'($urandom); v5 = DW'($urandom);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mode", 32'(mode), 2);      chk("rst_req", 32'(req), 0);
        chk("rst_locked", 32'(locked), 0);  chk("rst_lost", 32'(lost), 0);
        chk("rst_cvo", 32'(cvo), 0);        chk("rst_cinc", 32'(cinc_o), 0);
        chk("rst_miss", 32'(miss), 0);

        // Acquisition
        rst = 1'b0; en = 1'b1;
        idle(1);
        chk("search_mode", 32'(mode), 0);
        cyc(1'b1, r1, 1'b0, '0, 1'b1); pos = 0;
        chk("acq_req", 32'(req), 32'(r1)); chk("acq_mode", 32'(mode), 2);
        idle(2);
        cyc(1'b0, 2'd0, 1'b1, v1, 1'b1);
        chk("cfo1_valid", 32'(cvo), 1); chk("cfo1_val", 32'(cinc_o), 32'(v1));
        idle(1);
        chk("cfo1_pulse_end", 32'(cvo), 0);
        idle(P - W - pos);
        chk("wait_96", 32'(mode), 2);
        idle(1);
        chk("track_97", 32'(mode), 1);

        // Wrong ID in TRACK, with a CFO pulse that must not be forwarded
        cyc(1'b1, wrong, 1'b1, v2, 1'b1);
        chk("wrong_mode", 32'(mode), 1); chk("wrong_locked", 32'(locked), 0);
        chk("wrong_cvo", 32'(cvo), 0);   chk("wrong_cinc", 32'(cinc_o), 32'(v1));
        idle(P - pos);
        cyc(1'b1, r1, 1'b0, '0, 1'b1); pos = 0;
        chk("lock_locked", 32'(locked), 1); chk("lock_mode", 32'(mode), 2);
        chk("lock_miss", 32'(miss), 0);

        // CFO gating after a hit, then an early detection in WAIT
        idle(2);
        cyc(1'b0, 2'd0, 1'b1, v3, 1'b1);
        chk("cfo3_valid", 32'(cvo), 1); chk("cfo3_val", 32'(cinc_o), 32'(v3));
        cyc(1'b0, 2'd0, 1'b1, v4, 1'b1);
        chk("cfo4_drop", 32'(cvo), 0); chk("cfo4_hold", 32'(cinc_o), 32'(v3));
        idle(5);
        cyc(1'b1, r1, 1'b1, v4, 1'b1);
        chk("early_mode", 32'(mode), 2); chk("early_cvo", 32'(cvo), 0);
        idle(P - W - pos);
        chk("early_wait_96", 32'(mode), 2);
        idle(1);
        chk("early_track_97", 32'(mode), 1);

        // Miss recovery, then a hit exactly at window end
        idle(P + W - pos);
        chk("win_end_mode", 32'(mode), 1); chk("win_end_miss", 32'(miss), 0);
        idle(1); pos = W;
        chk("miss1_cnt", 32'(miss), 1); chk("miss1_locked", 32'(locked), 1);
        chk("miss1_mode", 32'(mode), 2);
        idle(P - W - pos);
        chk("miss1_wait_96", 32'(mode), 2);
        idle(1);
        chk("miss1_track", 32'(mode), 1);
        idle(P + W - pos);
        cyc(1'b1, r1, 1'b0, '0, 1'b1); pos = 0;
        chk("edge_hit_miss", 32'(miss), 0); chk("edge_hit_locked", 32'(locked), 1);
        chk("edge_hit_mode", 32'(mode), 2);

        // Lock loss after two consecutive misses
        idle(P + W);
        chk("ll_pre_lost", 32'(lost), 0);
        idle(1); pos = W;
        chk("ll_miss1", 32'(miss), 1);
        idle(P - W + 1 - pos);
        chk("ll_track", 32'(mode), 1);
        idle(P + W - pos);
        chk("ll_locked_hold", 32'(locked), 1);
        idle(1);
        chk("ll_lost", 32'(lost), 1);   chk("ll_locked", 32'(locked), 0);
        chk("ll_mode", 32'(mode), 0);   chk("ll_miss0", 32'(miss), 0);
        idle(1);
        chk("ll_lost_pulse", 32'(lost), 0); chk("ll_search", 32'(mode), 0);

        // Reacquire with CFO in the same cycle, then random strobes through WAIT
        cyc(1'b1, r2, 1'b1, v5, 1'b1); pos = 0;
        chk("re_req", 32'(req), 32'(r2)); chk("re_cvo", 32'(cvo), 1);
        chk("re_cinc", 32'(cinc_o), 32'(v5));
        got = 1'b0;
        pb = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            s = 1'($urandom_range(1, 0));
            pb = pos;
            cyc(1'b0, 2'd0, 1'b0, '0, s);
            if (mode == 2'd1) got = 1'b1;
        end
        chk("rnd_track_mode", 32'(mode), 1);
        chk("rnd_track_strobes", 32'(pb), P - W);
        hit_at = $urandom_range(P + W, P - W + 1);
        idle(hit_at - pos);
        cyc(1'b1, r2, 1'b0, '0, 1'b1); pos = 0;
        chk("rnd_hit_locked", 32'(locked), 1);

        // Asynchronous reset mid-TRACK
        idle(P - W + 1);
        chk("ar_track", 32'(mode), 1);
        #3 rst = 1'b1;
        #1;
        chk("ar_mode", 32'(mode), 2);    chk("ar_locked", 32'(locked), 0);
        chk("ar_req", 32'(req), 0);      chk("ar_cinc", 32'(cinc_o), 0);
        chk("ar_lost", 32'(lost), 0);    chk("ar_cvo", 32'(cvo), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("ar_idle", 32'(mode), 2);
        idle(1);
        chk("ar_search", 32'(mode), 0);

        // enable_i low while locked
        cyc(1'b1, r3, 1'b0, '0, 1'b1); pos = 0;
        idle(P);
        cyc(1'b1, r3, 1'b0, '0, 1'b1); pos = 0;
        chk("en_locked", 32'(locked), 1);
        idle(P - W + 1);
        en = 1'b0;
        idle(1);
        chk("en_mode", 32'(mode), 2);    chk("en_locked0", 32'(locked), 0);
        chk("en_lost", 32'(lost), 0);    chk("en_miss", 32'(miss), 0);
        idle(1);
        chk("en_lost2", 32'(lost), 0);
        en = 1'b1;
        idle(1);
        chk("en_search", 32'(mode), 0);

        // Misses without lock fall back silently
        cyc(1'b1, r4, 1'b0, '0, 1'b1); pos = 0;
        idle(P + W + 1); pos = W;
        chk("ul_miss1", 32'(miss), 1); chk("ul_locked", 32'(locked), 0);
        idle(P + W - pos);
        chk("ul_track", 32'(mode), 1);
        idle(1);
        chk("ul_search", 32'(mode), 0); chk("ul_no_lost", 32'(lost), 0);
        chk("ul_miss0", 32'(miss), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
